// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit
// Iterative restoring divider: one trial subtraction per clock, producing an
// unsigned quotient and remainder WIDTH cycles after an accepted start.
//
// Optional feature: define SEQ_DIVIDER_SIGNED_EN to add the signed_mode input.
// In signed mode the operand magnitudes are divided and the signs are restored
// at the completing edge (quotient truncates toward zero, remainder takes the
// dividend's sign).
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only when busy=0
//   dividend     in   numerator, captured with start
//   divisor      in   denominator, captured with start
//   signed_mode  in   (SEQ_DIVIDER_SIGNED_EN only) two's complement operands
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  quotient, held until the next completion
//   remainder    out  remainder, held until the next completion
//   div_by_zero  out  captured divisor was zero, held with results

module seq_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CALC} state_e;

    state_e           state_q;
    // The accepted partial remainder is always below the divisor, so its
    // WIDTH+1'th bit is permanently zero and is not stored.
    logic [WIDTH-1:0] rem_acc_q;
    logic [WIDTH-1:0] quo_sh_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] rem_acc_d;
    logic [WIDTH-1:0] quo_sh_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH-1:0] quo_fin_d;
    logic [WIDTH-1:0] rem_fin_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             a_neg_d;
    logic             b_neg_d;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [WIDTH-1:0] dividend_q;
`endif

    // Trial subtraction and operand magnitudes.
    always_comb begin
        shifted_d = {rem_acc_q, quo_sh_q[WIDTH-1]};
        diff_d    = shifted_d - {1'b0, divisor_q};
        if (!diff_d[WIDTH]) begin
            rem_acc_d = diff_d[WIDTH-1:0];
            quo_sh_d  = {quo_sh_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_acc_d = shifted_d[WIDTH-1:0];
            quo_sh_d  = {quo_sh_q[WIDTH-2:0], 1'b0};
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        a_neg_d   = signed_mode & dividend[WIDTH-1];
        b_neg_d   = signed_mode & divisor[WIDTH-1];
        mag_a_d   = a_neg_d ? (~dividend + 1'b1) : dividend;
        mag_b_d   = b_neg_d ? (~divisor + 1'b1) : divisor;
        quo_fin_d = (a_neg_q ^ b_neg_q) ? (~quo_sh_d + 1'b1) : quo_sh_d;
        rem_fin_d = a_neg_q ? (~rem_acc_d + 1'b1) : rem_acc_d;
        // Magnitude division by zero would return |dividend|; report the
        // raw dividend and an all-ones quotient regardless of signs.
        if (divisor_q == '0) begin
            quo_fin_d = '1;
            rem_fin_d = dividend_q;
        end
`else
        mag_a_d   = dividend;
        mag_b_d   = divisor;
        quo_fin_d = quo_sh_d;
        rem_fin_d = rem_acc_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_acc_q   <= '0;
            quo_sh_q    <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            dividend_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_acc_q <= '0;
                        quo_sh_q  <= mag_a_d;
                        divisor_q <= mag_b_d;
                        cnt_q     <= CW'(WIDTH - 1);
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        a_neg_q    <= a_neg_d;
                        b_neg_q    <= b_neg_d;
                        dividend_q <= dividend;
`endif
                    end
                end
                CALC: begin
                    rem_acc_q <= rem_acc_d;
                    quo_sh_q  <= quo_sh_d;
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient_q  <= quo_fin_d;
                        remainder_q <= rem_fin_d;
                        dbz_q       <= (divisor_q == '0);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
module tb_seq_divider_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic       signed_mode;
`endif
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sm);
        dividend = a;
        divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_mode = sm;
`else
        if (sm) $display("note: signed_mode ignored in unsigned build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; bounded to 20 cycles.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        do begin
            tick();
            lat++;
            if (busy) busy_n++;
        end while (!done && lat < 20);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_mode = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %0b expected 0", div_by_zero); end
    endtask

    task automatic test_basic;
        int lat, bn;
        start_op(8'd200, 8'd7, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %0b expected 1", busy); end
        wait_done(lat, bn);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b expected 1", done); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
        checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL basic_q: got %0d expected 28", quotient); end
        checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL basic_r: got %0d expected 4", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %0b expected 0", div_by_zero); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", done); end
        checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL basic_q_hold: got %0d expected 28", quotient); end
    endtask

    task automatic test_div_zero;
        int lat, bn;
        start_op(8'd5, 8'd0, 1'b0);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL dz_latency: got %0d expected 8", lat); end
        checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL dz_q: got %0d expected 255", quotient); end
        checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dz_r: got %0d expected 5", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %0b expected 1", div_by_zero); end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        start_op(8'd3, 8'd9, 1'b0);
        wait_done(lat, bn);
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL b2b_q1: got %0d expected 0", quotient); end
        checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL b2b_r1: got %0d expected 3", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b_dbz1: got %0b expected 0", div_by_zero); end
        // issued in the done cycle
        start_op(8'd255, 8'd1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %0b expected 1", busy); end
        checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL b2b_r_hold: got %0d expected 3", remainder); end
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
        checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL b2b_q2: got %0d expected 255", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL b2b_r2: got %0d expected 0", remainder); end
    endtask

    task automatic test_ignore_start;
        int lat = 0;
        int dcount = 0;
        start_op(8'd100, 8'd3, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin
                dividend = 8'd50; divisor = 8'd5; start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                dcount++;
                if (lat == 0) lat = n;
            end
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ign_latency: got %0d expected 8", lat); end
        checks++; if (dcount !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", dcount); end
        checks++; if (quotient !== 8'd33) begin errors++; $display("FAIL ign_q: got %0d expected 33", quotient); end
        checks++; if (remainder !== 8'd1) begin errors++; $display("FAIL ign_r: got %0d expected 1", remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, bn;
        int dcount = 0;
        start_op(8'd200, 8'd7, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %0b expected 0", done); end
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL rmid_q: got %0d expected 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL rmid_r: got %0d expected 0", remainder); end
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", dcount); end
        start_op(8'd9, 8'd2, 1'b0);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rmid_latency: got %0d expected 8", lat); end
        checks++; if (quotient !== 8'd4) begin errors++; $display("FAIL rmid_q2: got %0d expected 4", quotient); end
        checks++; if (remainder !== 8'd1) begin errors++; $display("FAIL rmid_r2: got %0d expected 1", remainder); end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed;
        int lat, bn;
        start_op(8'h9C, 8'h07, 1'b1);
        wait_done(lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL sgn_latency: got %0d expected 8", lat); end
        checks++; if (quotient !== 8'hF2) begin errors++; $display("FAIL sgn_q: got %h expected f2", quotient); end
        checks++; if (remainder !== 8'hFE) begin errors++; $display("FAIL sgn_r: got %h expected fe", remainder); end
        start_op(8'h80, 8'hFF, 1'b1);
        wait_done(lat, bn);
        checks++; if (quotient !== 8'h80) begin errors++; $display("FAIL sgn_ovf_q: got %h expected 80", quotient); end
        checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL sgn_ovf_r: got %h expected 00", remainder); end
        start_op(8'h9C, 8'h00, 1'b1);
        wait_done(lat, bn);
        checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL sgn_dz_q: got %h expected ff", quotient); end
        checks++; if (remainder !== 8'h9C) begin errors++; $display("FAIL sgn_dz_r: got %h expected 9c", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL sgn_dz_flag: got %0b expected 1", div_by_zero); end
        start_op(8'h9C, 8'h07, 1'b0);
        wait_done(lat, bn);
        checks++; if (quotient !== 8'd22) begin errors++; $display("FAIL sgn_off_q: got %0d expected 22", quotient); end
        checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL sgn_off_r: got %0d expected 2", remainder); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
